// File: rtl/sm3_pad_sched.sv
// Two-requester round-robin scheduler feeding serial messages into an SM3 padding unit.
// Optional GRANT watchdog enabled by defining SM3_PAD_SCHED_WDOG_EN.
module sm3_pad_sched #(
    parameter int MAX_BITS   = 447,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] in_data,
    input  logic [1:0] in_en,
    output logic       pad_data,
    output logic       pad_en,
    input  logic       pad_out_en,
    output logic       busy,
    output logic [1:0] done,
    output logic       err,
    output logic       timeout
);

    localparam int          GAP_W   = $clog2(GAP_CYCLES);
    localparam logic [10:0] MAX_CNT = 11'(MAX_BITS);
    localparam logic [9:0]  PAD_LEN = 10'd512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t           state;
    logic             sel;        // latched winner
    logic             prio;       // requester favoured on a tie
    logic [10:0]      bit_cnt;
    logic [9:0]       pad_cnt;
    logic             pad_seen;
    logic             trunc_chk;
    logic [GAP_W-1:0] gap_cnt;
    logic             win;
`ifdef SM3_PAD_SCHED_WDOG_EN
    logic [7:0]       wdog;
`endif

    assign win  = (req == 2'b11) ? prio : req[1];
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            prio      <= 1'b0;
            gnt       <= 2'b00;
            pad_data  <= 1'b0;
            pad_en    <= 1'b0;
            done      <= 2'b00;
            err       <= 1'b0;
            bit_cnt   <= '0;
            pad_cnt   <= '0;
            pad_seen  <= 1'b0;
            trunc_chk <= 1'b0;
            gap_cnt   <= '0;
`ifdef SM3_PAD_SCHED_WDOG_EN
            timeout   <= 1'b0;
            wdog      <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low every cycle; the case below raises them for one edge only.
            done <= 2'b00;
`ifdef SM3_PAD_SCHED_WDOG_EN
            timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    pad_en <= 1'b0;
                    if (req != 2'b00) begin
                        sel       <= win;
                        gnt       <= 2'b01 << win;
                        prio      <= ~win;
                        bit_cnt   <= '0;
                        pad_cnt   <= '0;
                        pad_seen  <= 1'b0;
                        trunc_chk <= 1'b0;
`ifdef SM3_PAD_SCHED_WDOG_EN
                        wdog      <= '0;
`endif
                        state     <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    if (in_en[sel]) begin
                        pad_en   <= 1'b1;
                        pad_data <= in_data[sel];
                        bit_cnt  <= 11'd1;
                        if (MAX_CNT == 11'd1) begin
                            gnt       <= 2'b00;
                            trunc_chk <= 1'b1;
                            state     <= S_DRAIN;
                        end else begin
                            state <= S_XFER;
                        end
                    end else if (!req[sel]) begin
                        gnt   <= 2'b00;
                        state <= S_IDLE;
                    end
`ifdef SM3_PAD_SCHED_WDOG_EN
                    else if (wdog == 8'hfe) begin
                        timeout <= 1'b1;
                        gnt     <= 2'b00;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end

                S_XFER: begin
                    if (in_en[sel]) begin
                        pad_en   <= 1'b1;
                        pad_data <= in_data[sel];
                        bit_cnt  <= bit_cnt + 11'd1;
                        // Reaching the limit: leave now and let DRAIN see if the burst kept going.
                        if (bit_cnt + 11'd1 == MAX_CNT) begin
                            gnt       <= 2'b00;
                            trunc_chk <= 1'b1;
                            state     <= S_DRAIN;
                        end
                    end else begin
                        pad_en <= 1'b0;
                        gnt    <= 2'b00;
                        state  <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    pad_en    <= 1'b0;
                    trunc_chk <= 1'b0;
                    if (trunc_chk && in_en[sel]) begin
                        err <= 1'b1;
                    end
                    if (pad_out_en) begin
                        pad_seen <= 1'b1;
                        if (pad_cnt != 10'h3ff) begin
                            pad_cnt <= pad_cnt + 10'd1;
                        end
                    end else if (pad_seen) begin
                        done    <= 2'b01 << sel;
                        if (pad_cnt != PAD_LEN) begin
                            err <= 1'b1;
                        end
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    pad_en <= 1'b0;
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

`ifndef SM3_PAD_SCHED_WDOG_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/sm3_pad_sched.md
SM3_PAD_SCHED -- requirements
Module: sm3_pad_sched

Interface
REQ-001 Parameter MAX_BITS, default 447: maximum message length in bits forwarded per grant.
REQ-002 Parameter GAP_CYCLES, default 4, minimum 2: idle cycles inserted between consecutive messages.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester request to send one message.
REQ-006 gnt  output  2  one-hot grant; at most one bit high.
REQ-007 in_data  input  2  per-requester serial message bit.
REQ-008 in_en  input  2  per-requester bit valid; one contiguous high burst per message.
REQ-009 pad_data  output  1  serial bit to the padding unit's data input.
REQ-010 pad_en  output  1  valid to the padding unit's data_en input.
REQ-011 pad_out_en  input  1  padding unit's data_padding_en, monitored for completion.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  2  one-cycle pulse on the bit of the requester whose padded stream completed.
REQ-014 err  output  1  sticky; set on truncation or bad padded length; cleared only by rst.
REQ-015 timeout  output  1  one-cycle pulse on watchdog abort (see Configuration).

Function
REQ-016 FSM states: IDLE, GRANT, XFER, DRAIN, GAP.
REQ-017 IDLE: if req!=0, latch winner w, assert gnt[w] next cycle, go GRANT.
REQ-018 Arbitration: round-robin; requester that did not win last is chosen on a tie; after reset, requester 0 wins a tie.
REQ-019 GRANT: in_en[w] high -> XFER. req[w] low with in_en[w] low -> drop gnt, go IDLE.
REQ-020 in_data/in_en from the non-granted requester are ignored in all states.
REQ-021 XFER: pad_data/pad_en are in_data[w]/in_en[w] registered, exactly 1 cycle latency.
REQ-022 An 11-bit counter counts forwarded bits. Once MAX_BITS bits are forwarded, pad_en is forced low and err is set.
REQ-023 XFER exits to DRAIN on the first cycle in_en[w] is low, or on reaching MAX_BITS. gnt drops on the same edge.
REQ-024 DRAIN: a 10-bit counter counts pad_out_en high cycles. When pad_out_en falls after having risen, pulse done[w] and go GAP.
REQ-025 DRAIN: a padded count other than 512 at completion sets err.
REQ-026 GAP: pad_en low for GAP_CYCLES cycles, then IDLE. Requests are not sampled in GAP.
REQ-027 req changes during XFER/DRAIN/GAP are ignored. A req still high on return to IDLE is arbitrated normally.
REQ-028 pad_en is never high outside XFER plus its 1-cycle pipeline tail.

Reset
REQ-029 rst high, including mid-operation: state IDLE, gnt=0, pad_data=0, pad_en=0, busy=0, done=0, err=0, timeout=0, counters 0, round-robin pointer favours requester 0.
REQ-030 Outputs take reset values asynchronously. The first arbitration occurs on the first rising edge after rst falls.

Configuration
REQ-031 Macro SM3_PAD_SCHED_WDOG_EN defined: an 8-bit watchdog counts cycles in GRANT.
REQ-032 With the macro, 255 cycles in GRANT without in_en[w] -> pulse timeout, drop gnt, go GAP.
REQ-033 Macro undefined: no watchdog; GRANT waits indefinitely; timeout is tied 0.

Verification
REQ-034 req=01, 16-bit burst on in_en[0] -> gnt=01 one cycle later; 16 pad_en cycles delayed 1 cycle; 512 pad_out_en cycles -> done=01 pulse; err=0.
REQ-035 req=11 from reset -> gnt=01 first. After its done and GAP, gnt=10. With req=11 held, the next grant is 01.
REQ-036 500-bit burst on in_en[1] -> exactly 447 pad_en cycles; err=1 stays set until rst.
REQ-037 Padding unit model emits 511 pad_out_en cycles -> done pulses and err=1.
REQ-038 rst asserted during XFER at bit 100 -> pad_en, gnt, busy low immediately; after release, req=10 is granted normally.
REQ-039 SM3_PAD_SCHED_WDOG_EN defined, req=01, in_en never rises -> timeout pulse after 255 GRANT cycles, gnt=00, IDLE after GAP_CYCLES.
